// File: rtl/romulus_cnt_pkg.sv
// Shared definitions for the Romulus TK1 counter-half schedule: FSM encoding,
// schedule constants and the byte permutations applied between rounds.
package romulus_cnt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEEK = 2'd1,
    ST_EMIT = 2'd2
  } cnt_state_e;

  localparam int CNT_PERIOD     = 8;
  localparam int ROUNDS_DEFAULT = 40;

  // 3-bit group i names the source byte of output byte i (group 7 is the MSB group).
  localparam logic [23:0] FWD_SRC_MAP = {3'd6, 3'd0, 3'd7, 3'd2, 3'd5, 3'd1, 3'd3, 3'd4};
  localparam logic [23:0] INV_SRC_MAP = {3'd5, 3'd7, 3'd3, 3'd0, 3'd1, 3'd4, 3'd2, 3'd6};

  function automatic logic [63:0] byte_perm(input logic [63:0] d, input logic [23:0] src_map);
    logic [63:0] q;
    q = 64'd0;
    for (int i = 0; i < 8; i++) begin
      q[8*i +: 8] = d[8*int'(src_map[3*i +: 3]) +: 8];
    end
    return q;
  endfunction

  function automatic logic [63:0] perm_fwd(input logic [63:0] d);
    return byte_perm(d, FWD_SRC_MAP);
  endfunction

  function automatic logic [63:0] perm_inv(input logic [63:0] d);
    return byte_perm(d, INV_SRC_MAP);
  endfunction

endpackage

// File: rtl/cnt_contraction.sv
// Combinational inverse counter byte permutation (P^-1), stepping a round key
// one round backwards.
module cnt_contraction
  import romulus_cnt_pkg::*;
(
  input  logic [63:0] key,
  output logic [63:0] key_inv
);

  assign key_inv = perm_inv(key);

endmodule

// File: rtl/cnt_rev_schedule.sv
// Reverse-order round-key generator for the TK1 counter half: fast-forwards the
// round-0 key to the last round, then streams keys down to round 0.
module cnt_rev_schedule
  import romulus_cnt_pkg::*;
#(
  parameter int ROUNDS = ROUNDS_DEFAULT,
  parameter int RW     = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic [63:0]   key_i,
  output logic          busy_o,
  output logic [63:0]   rk_o,
  output logic [RW-1:0] rk_round_o,
  output logic          rk_valid_o,
  input  logic          rk_ready_i,
  output logic          rk_last_o,
  output logic          done_o
);

  localparam int             SEEK_STEPS = (ROUNDS - 1) % CNT_PERIOD;
  localparam logic [2:0]     SEEK_INIT  = 3'(SEEK_STEPS);
  localparam logic [RW-1:0]  LAST_RND   = RW'(ROUNDS - 1);
  localparam logic [RW-1:0]  RND_ZERO   = RW'(0);
  localparam logic [RW-1:0]  RND_ONE    = RW'(1);

  cnt_state_e    state_r;
  logic [63:0]   key_r;
  logic [RW-1:0] rnd_r;
  logic [2:0]    seek_cnt_r;
  logic [63:0]   key_inv_s;

  cnt_contraction u_contraction (
    .key     (key_r),
    .key_inv (key_inv_s)
  );

  // Schedule FSM; the first EMIT cycle only loads the output registers, so
  // every output is a flop and rk_ready_i never reaches an output combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      key_r      <= 64'd0;
      rnd_r      <= RND_ZERO;
      seek_cnt_r <= 3'd0;
      busy_o     <= 1'b0;
      rk_o       <= 64'd0;
      rk_round_o <= RND_ZERO;
      rk_valid_o <= 1'b0;
      rk_last_o  <= 1'b0;
      done_o     <= 1'b0;
    end else begin
      done_o <= 1'b0;
      if (abort) begin
        state_r    <= ST_IDLE;
        busy_o     <= 1'b0;
        rk_valid_o <= 1'b0;
        rk_last_o  <= 1'b0;
      end else begin
        case (state_r)
          ST_IDLE: begin
            if (start) begin
              key_r      <= key_i;
              seek_cnt_r <= SEEK_INIT;
              rnd_r      <= LAST_RND;
              busy_o     <= 1'b1;
              state_r    <= (SEEK_INIT != 3'd0) ? ST_SEEK : ST_EMIT;
            end else begin
              busy_o <= 1'b0;
            end
          end
          ST_SEEK: begin
            key_r      <= perm_fwd(key_r);
            seek_cnt_r <= seek_cnt_r - 3'd1;
            if (seek_cnt_r == 3'd1) begin
              state_r <= ST_EMIT;
            end else begin
              state_r <= ST_SEEK;
            end
          end
          ST_EMIT: begin
            if (!rk_valid_o) begin
              rk_valid_o <= 1'b1;
              rk_o       <= key_r;
              rk_round_o <= rnd_r;
              rk_last_o  <= (rnd_r == RND_ZERO);
            end else if (rk_ready_i) begin
              if (rnd_r == RND_ZERO) begin
                state_r    <= ST_IDLE;
                busy_o     <= 1'b0;
                rk_valid_o <= 1'b0;
                rk_last_o  <= 1'b0;
                done_o     <= 1'b1;
              end else begin
                key_r      <= key_inv_s;
                rnd_r      <= rnd_r - RND_ONE;
                rk_o       <= key_inv_s;
                rk_round_o <= rnd_r - RND_ONE;
                rk_last_o  <= (rnd_r == RND_ONE);
              end
            end else begin
              rk_valid_o <= 1'b1;
            end
          end
          default: begin
            state_r    <= ST_IDLE;
            busy_o     <= 1'b0;
            rk_valid_o <= 1'b0;
            rk_last_o  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cnt_rev_schedule.sv
// Self-checking bench for cnt_rev_schedule: directed table vectors, multi-cycle
// corner sequences and randomized streams against a P^(r mod 8) reference model.
module tb_cnt_rev_schedule;

  localparam int ROUNDS = 40;
  localparam int RW     = 6;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start, abort, rk_ready;
  logic [63:0]   key_i;
  logic          busy, rk_valid, rk_last, done;
  logic [63:0]   rk;
  logic [RW-1:0] rk_round;

  logic          start1, abort1, ready1;
  logic [63:0]   key1;
  logic          busy1, valid1, last1, done1;
  logic [63:0]   rk1;
  logic [0:0]    round1;

  int checks = 0;
  int errors = 0;
  logic [63:0] seen_key [ROUNDS];

  // Output byte i takes input byte fwd_src[i].
  int fwd_src [8] = '{4, 3, 1, 5, 2, 7, 0, 6};

  typedef struct {
    int          rnd;
    logic [63:0] key;
  } vec_t;
  vec_t tbl [5];

  always #5 clk = ~clk;

  cnt_rev_schedule #(.ROUNDS(ROUNDS), .RW(RW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .key_i(key_i),
    .busy_o(busy), .rk_o(rk), .rk_round_o(rk_round), .rk_valid_o(rk_valid),
    .rk_ready_i(rk_ready), .rk_last_o(rk_last), .done_o(done)
  );

  cnt_rev_schedule #(.ROUNDS(1), .RW(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .key_i(key1),
    .busy_o(busy1), .rk_o(rk1), .rk_round_o(round1), .rk_valid_o(valid1),
    .rk_ready_i(ready1), .rk_last_o(last1), .done_o(done1)
  );

  function automatic logic [63:0] p_fwd(input logic [63:0] d);
    logic [63:0] q;
    for (int i = 0; i < 8; i++) q[8*i +: 8] = d[8*fwd_src[i] +: 8];
    return q;
  endfunction

  function automatic logic [63:0] model_key(input logic [63:0] k0, input int r);
    logic [63:0] k;
    k = k0;
    for (int i = 0; i < (r % 8); i++) k = p_fwd(k);
    return k;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode 0: ready always high; 1: random ready; 2: 5-cycle stall at round 20 plus start while busy.
  // Returns in the cycle done_o is expected high.
  task automatic run_stream(input logic [63:0] k, input int mode);
    int cyc;
    int exp_rnd;
    int hold;
    logic hs;
    logic finished;
    key_i = k;
    start = 1'b1;
    tick();
    start = 1'b0;
    key_i = 64'd0;
    chk("busy_after_start", {63'd0, busy}, 64'd1);
    chk("done_one_cycle", {63'd0, done}, 64'd0);
    cyc = 0;
    if (mode == 2) begin
      key_i = ~k;
      start = 1'b1;
      tick();
      start = 1'b0;
      key_i = 64'd0;
      cyc = 1;
    end
    while (!rk_valid && cyc < 50) begin
      tick();
      cyc++;
    end
    chk("first_beat_latency", 64'(cyc), 64'd8);
    exp_rnd = ROUNDS - 1;
    hold = 0;
    finished = 1'b0;
    for (int n = 0; n < 4000; n++) begin
      chk("valid_high", {63'd0, rk_valid}, 64'd1);
      chk("rk_round", 64'(rk_round), 64'(exp_rnd));
      chk("rk_key", rk, model_key(k, exp_rnd));
      chk("rk_last", {63'd0, rk_last}, {63'd0, exp_rnd == 0});
      if (mode == 0) seen_key[exp_rnd] = rk;
      if (mode == 0) rk_ready = 1'b1;
      else if (mode == 1) rk_ready = ($urandom_range(7) != 0);
      else if (exp_rnd == 20 && hold < 5) begin
        rk_ready = 1'b0;
        hold++;
      end else rk_ready = 1'b1;
      hs = rk_ready;
      tick();
      if (hs) begin
        if (exp_rnd == 0) begin
          finished = 1'b1;
          break;
        end
        exp_rnd--;
      end
    end
    rk_ready = 1'b0;
    chk("stream_complete", {63'd0, finished}, 64'd1);
    if (mode == 2) chk("stall_cycles", 64'(hold), 64'd5);
    chk("done_pulse", {63'd0, done}, 64'd1);
    chk("busy_low_at_done", {63'd0, busy}, 64'd0);
    chk("valid_low_at_done", {63'd0, rk_valid}, 64'd0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    logic any_valid;
    rst_n = 1'b0;
    start = 1'b0; abort = 1'b0; rk_ready = 1'b0; key_i = 64'd0;
    start1 = 1'b0; abort1 = 1'b0; ready1 = 1'b0; key1 = 64'd0;
    tbl[0] = '{39, 64'h0507030001040206};
    tbl[1] = '{38, 64'h0305010602000407};
    tbl[2] = '{32, 64'h0706050403020100};
    tbl[3] = '{31, 64'h0507030001040206};
    tbl[4] = '{0,  64'h0706050403020100};
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_valid", {63'd0, rk_valid}, 64'd0);
    chk("reset_rk", rk, 64'd0);
    chk("reset_round", 64'(rk_round), 64'd0);
    chk("reset_last_done", {62'd0, rk_last, done}, 64'd0);

    // Directed stream, then a back-to-back start in the done cycle.
    run_stream(64'h0706050403020100, 0);
    for (int i = 0; i < 5; i++)
      chk($sformatf("table_rk_r%0d", tbl[i].rnd), seen_key[tbl[i].rnd], tbl[i].key);
    run_stream(64'h1122334455667788, 0);
    tick();
    chk("done_cleared", {63'd0, done}, 64'd0);

    // Backpressure at round 20 with a start pulse while busy.
    run_stream(64'hdeadbeef01234567, 2);
    tick();

    // Abort during SEEK.
    key_i = 64'h0f0e0d0c0b0a0908;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_seek_busy", {63'd0, busy}, 64'd0);
    chk("abort_seek_valid", {63'd0, rk_valid}, 64'd0);
    any_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      any_valid |= rk_valid | done;
      tick();
    end
    chk("abort_seek_quiet", {63'd0, any_valid}, 64'd0);

    // start coinciding with abort in IDLE is ignored.
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("abort_start_ignored", {63'd0, busy}, 64'd0);

    // Abort at round 10 of EMIT, then restart from round 39.
    key_i = 64'h0123456789abcdef;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 0;
    rk_ready = 1'b1;
    while (!(rk_valid && rk_round == 6'd10) && cyc < 100) begin
      tick();
      cyc++;
    end
    chk("reach_round10", 64'(rk_round), 64'd10);
    rk_ready = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_emit_valid", {63'd0, rk_valid}, 64'd0);
    chk("abort_emit_busy", {63'd0, busy}, 64'd0);
    chk("abort_emit_done", {63'd0, done}, 64'd0);
    tick();
    chk("abort_emit_no_done", {63'd0, done}, 64'd0);
    run_stream(64'h0123456789abcdef, 0);
    tick();

    // Asynchronous reset in the middle of EMIT.
    key_i = 64'hcafef00d5a5a3c3c;
    start = 1'b1;
    tick();
    start = 1'b0;
    rk_ready = 1'b1;
    repeat (15) tick();
    chk("pre_reset_valid", {63'd0, rk_valid}, 64'd1);
    rk_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", {rk ^ 64'(rk_round), 60'd0, busy, rk_valid, rk_last, done}, 128'd0);
    chk("async_reset_rk", rk, 64'd0);
    #1;
    rst_n = 1'b1;
    tick();
    chk("post_reset_idle", {62'd0, busy, rk_valid}, 64'd0);

    // Single-round instance: no seek phase.
    key1 = 64'h0123456789abcdef;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    chk("r1_busy", {63'd0, busy1}, 64'd1);
    chk("r1_not_yet_valid", {63'd0, valid1}, 64'd0);
    tick();
    chk("r1_valid", {63'd0, valid1}, 64'd1);
    chk("r1_round", 64'(round1), 64'd0);
    chk("r1_key", rk1, 64'h0123456789abcdef);
    chk("r1_last", {63'd0, last1}, 64'd1);
    ready1 = 1'b1;
    tick();
    ready1 = 1'b0;
    chk("r1_done", {63'd0, done1}, 64'd1);
    chk("r1_busy_low", {63'd0, busy1}, 64'd0);
    tick();
    chk("r1_done_pulse", {63'd0, done1}, 64'd0);

    // Randomized keys and backpressure.
    for (int r = 0; r < 1000; r++) begin
      run_stream({$urandom(), $urandom()}, 1);
    end
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
